// File: rtl/uart_tx_ctrl_if.sv
// UART transmit frame-controller bundle.
// Carries the byte handshake, the parity configuration, the serializer
// link (ser_data/ser_done in, ser_en/busy out), the TX line and the
// sequence-error flag.
//   master : byte source + serializer side (drives P_DATA, Data_Valid,
//            PAR_EN, PAR_TYP, ser_data, ser_done)
//   slave  : frame controller (drives ser_en, busy, TX_OUT, seq_err)
interface uart_tx_ctrl_if;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;
  logic       seq_err;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, busy, TX_OUT, seq_err
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, busy, TX_OUT, seq_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller.
// Sequences start, 8 data bits (LSB first, taken from the serializer),
// optional parity and STOP_BITS stop bits onto TX_OUT. CLK is the bit clock.
// Ports:
//   CLK    : bit-rate clock, rising edge
//   RST    : asynchronous reset, active low
//   tx_if  : slave side of uart_tx_ctrl_if (handshake, parity config,
//            serializer link, TX line, sticky seq_err)
module uart_tx_ctrl #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave tx_if
);

  // Any STOP_BITS other than 2 behaves as 1; 1-bit counter is sufficient.
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     r_state;
  state_t     w_nxt_state;
  logic [2:0] r_bit_idx;
  logic       r_stop_cnt;
  logic       r_par;
  logic       r_par_en;
  logic       r_busy;
  logic       r_seq_err;

  logic       w_accept;
  logic       w_chk;
  logic       w_tx;
  logic       w_ser_en;

  assign w_accept = (r_state == IDLE) && !r_busy && tx_if.Data_Valid;

  // First cycle after DATA: PARITY, or the first STOP when no parity bit.
  assign w_chk = (r_state == PARITY) ||
                 ((r_state == STOP) && !r_par_en && (r_stop_cnt == 1'b0));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_tx        = 1'b1;
    w_ser_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nxt_state = START;
      end
      START: begin
        w_tx        = 1'b0;
        w_nxt_state = DATA;
      end
      DATA: begin
        w_tx     = tx_if.ser_data;
        w_ser_en = 1'b1;
        if (r_bit_idx == 3'd7) w_nxt_state = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        w_tx        = r_par;
        w_nxt_state = STOP;
      end
      STOP: begin
        if (r_stop_cnt == STOP_LAST) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_par_en <= tx_if.PAR_EN;
        r_par    <= (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
      end

      if (r_state == START)     r_bit_idx <= '0;
      else if (r_state == DATA) r_bit_idx <= r_bit_idx + 3'd1;

      if (r_state == STOP) r_stop_cnt <= r_stop_cnt + 1'b1;
      else                 r_stop_cnt <= 1'b0;

      // busy follows the state register so it rises on acceptance and
      // falls on the edge that re-enters IDLE.
      r_busy <= (w_nxt_state != IDLE);

      if (w_chk && !tx_if.ser_done) r_seq_err <= 1'b1;
    end
  end

  assign tx_if.TX_OUT  = w_tx;
  assign tx_if.ser_en  = w_ser_en;
  assign tx_if.busy    = r_busy;
  assign tx_if.seq_err = r_seq_err;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmitter. It accepts a byte handshake, drives the byte serializer (enable and busy), computes the parity bit, and muxes start, data, parity and stop bits onto the TX line. The block sits directly downstream of the serializer and consumes its serial data bit and done flag. CLK is the bit-rate clock: one CLK period is one UART bit time.

Parameters:
STOP_BITS, 1, number of stop bits per frame; legal values are 1 and 2; any other value is treated as 1.

Ports:
CLK  in  1  bit-rate clock, rising-edge.
RST  in  1  asynchronous, active-low reset.
P_DATA  in  8  parallel byte; used only to compute parity at acceptance.
Data_Valid  in  1  one-cycle strobe; the byte is accepted when Data_Valid=1 and busy=0.
PAR_EN  in  1  1 = parity bit present in the frame.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
ser_data  in  1  current serial bit from the serializer (its bit 0).
ser_done  in  1  serializer completion flag.
ser_en  out  1  serializer shift enable; also fed to the serializer.
busy  out  1  frame in progress; wired to the serializer busy input.
TX_OUT  out  1  UART line, idle high.
seq_err  out  1  sticky flag: the serializer did not complete in step with the FSM.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. The state register, bit index (3 bits), stop counter and latched parity are all registered.
- Reset (RST=0, asynchronous, effective immediately, including mid-frame):
  - state goes to IDLE;
  - TX_OUT=1, busy=0, ser_en=0, seq_err=0;
  - bit index = 0, latched parity = 0.
- IDLE: TX_OUT=1, busy=0, ser_en=0.
  - On an edge with Data_Valid=1, the block latches PAR_EN and PAR_TYP.
  - On the same edge it latches parity = (^P_DATA) XOR PAR_TYP.
  - It then moves to START. The serializer loads the byte on the same edge.
- START (1 cycle): TX_OUT=0, busy=1, ser_en=0. Next state is DATA with bit index = 0.
- DATA (8 cycles): TX_OUT=ser_data, busy=1, ser_en=1.
  - The serializer shifts at the end of each DATA cycle, so bits go out LSB first.
  - Bit index increments each cycle. After index 7, the next state is PARITY if latched PAR_EN=1, otherwise STOP.
- PARITY (1 cycle): TX_OUT=latched parity, busy=1, ser_en=0. Next state is STOP.
- STOP (STOP_BITS cycles): TX_OUT=1, busy=1, ser_en=0. After the last stop cycle, the next state is IDLE.
- ser_en=1 only in DATA. This is mandatory: the serializer down-counter wraps if it is enabled after completion.
- seq_err check:
  - Evaluated on the first cycle after DATA (PARITY, or first STOP).
  - If ser_done=0 on that cycle, seq_err is set at the next edge.
  - seq_err stays set until reset.
  - ser_done is ignored in every other state.
- Data_Valid while busy=1 is ignored: no latch, no state change.
- Changes to PAR_EN, PAR_TYP or P_DATA mid-frame have no effect on the current frame.
- busy is registered: it goes high on the acceptance edge and low on the edge entering IDLE.
  - Minimum of one IDLE cycle between frames.
  - Frame period = 10 + PAR_EN + STOP_BITS cycles, including that one IDLE cycle.
- TX_OUT is a combinational mux of registered state, latched parity and ser_data. The serializer drives ser_data from a register, so TX_OUT is glitch-free per bit.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP_BITS=1 -> TX_OUT from the cycle after acceptance is 0,1,0,1,0,0,1,0,1,0,1; busy high for exactly 11 cycles; seq_err=0.
- 0xA5 with PAR_TYP=1 -> same frame but parity bit=1; a change of PAR_TYP to 0 during DATA does not alter the frame.
- P_DATA=0x3C, PAR_EN=0 -> TX_OUT is 0,0,0,1,1,1,1,0,0,1 (10 cycles); ser_en high for exactly 8 cycles, in cycles 2-9 of the frame.
- Frame 0x55 in progress, Data_Valid pulsed with 0xFF in DATA and again in STOP -> both pulses ignored; next accepted Data_Valid in IDLE with 0xFF produces data bits all 1 and even parity 0.
- Reset asserted during DATA bit 3 of 0x81 -> TX_OUT=1, busy=0, ser_en=0 immediately; after release, IDLE, and a new frame 0x0F transmits correctly.
- STOP_BITS=2, 0x00, PAR_EN=1, PAR_TYP=0 -> frame is 0, 0x8 zeros, 0, 1, 1 (12 cycles).
- Bench forces ser_done=0 after DATA -> seq_err=1 from the next edge and held until RST.
